perceptron_mac_controller: RTL

Sequences one shared sign-magnitude fixed-point multiplier (Q_M.Q_N, bit W-1 = sign) to evaluate a single perceptron neuron.
- Holds N_INPUTS weights in a register file and accepts input samples over a valid/ready stream.
- Multiply-accumulates each sample with its weight, adds a bias, then presents the weighted sum and a step activation over an output valid/ready handshake.
- The multiplier is instantiated outside this block; this block only drives its operands and reads its combinational product.

---
 rtl/perceptron_pkg.sv | 28 ++
 rtl/sm_saturating_adder.sv | 10 +
 rtl/perceptron_mac_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: Q17.16 sign-magnitude types, FSM states and saturating add.
package perceptron_pkg;
  localparam int Q_M = 17;
  localparam int Q_N = 16;
  localparam int W = Q_M + Q_N;
  typedef logic [W-1:0] sm_t;
  typedef enum logic [2:0] {IDLE, LOAD, MULT, BIAS, OUT} state_t;
  function automatic logic sm_sign(sm_t v);
    return v[W-1];
  endfunction
  function automatic logic [W-2:0] sm_mag(sm_t v);
    return v[W-2:0];
  endfunction
  // Zero magnitude always comes out with a positive sign.
  function automatic sm_t sm_sat_add(sm_t a, sm_t b);
    logic [W-1:0] s;
    logic [W-2:0] ma, mb, d;
    logic sg;
    ma = sm_mag(a);
    mb = sm_mag(b);
    s = {1'b0, ma} + {1'b0, mb};
    d = ma >= mb ? ma - mb : mb - ma;
    sg = ma >= mb ? sm_sign(a) : sm_sign(b);
    if (sm_sign(a) == sm_sign(b))
      return s[W-1] ? {sm_sign(a), {(W-1){1'b1}}} : {sm_sign(a) & |s[W-2:0], s[W-2:0]};
    return {sg & |d, d};
  endfunction
endpackage

// File: rtl/sm_saturating_adder.sv
// sm_saturating_adder: combinational sign-magnitude add with magnitude saturation.
module sm_saturating_adder
  import perceptron_pkg::*;
(
  input  sm_t a,
  input  sm_t b,
  output sm_t y
);
  assign y = sm_sat_add(a, b);
endmodule

// File: rtl/perceptron_mac_controller.sv
// perceptron_mac_controller: sequences an external sign-magnitude multiplier for one neuron.
// Define PERCEPTRON_RELU_EN to clamp negative sums to zero on y_sum_o.
module perceptron_mac_controller #(
  parameter int Q_M = 17,
  parameter int Q_N = 16,
  parameter int N_INPUTS = 4,
  localparam int W = Q_M + Q_N,
  localparam int IDX_W = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             w_we_i,
  input  logic [IDX_W-1:0] w_addr_i,
  input  logic [W-1:0]     w_data_i,
  input  logic             start_i,
  input  logic [W-1:0]     bias_i,
  input  logic             x_valid_i,
  input  logic [W-1:0]     x_data_i,
  output logic             x_ready_o,
  output logic [W-1:0]     mul_a_o,
  output logic [W-1:0]     mul_b_o,
  input  logic [W-1:0]     mul_y_i,
  output logic             y_valid_o,
  input  logic             y_ready_i,
  output logic [W-1:0]     y_sum_o,
  output logic             y_act_o,
  output logic             busy_o
);
  import perceptron_pkg::*;
  state_t state;
  logic [W-1:0] weight [N_INPUTS];
  logic [W-1:0] acc, bias_q, addend, sum, y_next;
  logic [IDX_W-1:0] idx;
  assign addend = state == MULT ? mul_y_i : bias_q;
  sm_saturating_adder u_add (.a(acc), .b(addend), .y(sum));
`ifdef PERCEPTRON_RELU_EN
  assign y_next = acc[W-1] ? '0 : acc;
`else
  assign y_next = acc;
`endif
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      for (int i = 0; i < N_INPUTS; i++) weight[i] <= '0;
      acc <= '0;
      bias_q <= '0;
      idx <= '0;
      mul_a_o <= '0;
      mul_b_o <= '0;
      y_sum_o <= '0;
      x_ready_o <= 1'b0;
      y_valid_o <= 1'b0;
      y_act_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_we_i) weight[w_addr_i] <= w_data_i;
          if (start_i) begin
            acc <= '0;
            idx <= '0;
            bias_q <= bias_i;
            state <= LOAD;
            x_ready_o <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        LOAD: if (x_valid_i) begin
          mul_a_o <= x_data_i;
          mul_b_o <= weight[idx];
          x_ready_o <= 1'b0;
          state <= MULT;
        end
        MULT: begin
          acc <= sum;
          if (idx == IDX_W'(N_INPUTS - 1)) state <= BIAS;
          else begin
            idx <= idx + 1'b1;
            x_ready_o <= 1'b1;
            state <= LOAD;
          end
        end
        BIAS: begin
          acc <= sum;
          state <= OUT;
        end
        OUT: begin
          // First OUT cycle registers the result; it is then held until consumed.
          if (!y_valid_o) begin
            y_valid_o <= 1'b1;
            y_sum_o <= y_next;
            y_act_o <= !acc[W-1] && |acc[W-2:0];
          end else if (y_ready_i) begin
            y_valid_o <= 1'b0;
            busy_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
